// File: rtl/polyvec_eta_scheduler.sv
// ---------------------------------------------------------------------------
// polyvec_eta_scheduler
//
// Drives the single shared poly_uniform_eta engine to produce the secret
// vectors s1 (L polynomials, nonces 0..L-1) and s2 (K polynomials, nonces
// L..L+K-1). A run latches a 512-bit seed, then issues L+K requests over the
// engine's level start/done handshake. Each 256-coefficient result is
// registered and written into the downstream polynomial store at slot = nonce.
//
// Ports
//   clock      in   1     clock
//   reset      in   1     synchronous, active-high reset
//   start      in   1     run request, sampled only while idle
//   seed       in   512   rho' seed, latched when a run is accepted
//   busy       out  1     high from accepted start until done
//   done       out  1     one-cycle pulse after the last write
//   eta_start  out  1     level request to the engine, held until eta_done
//   eta_seed   out  512   latched seed, stable for the whole run
//   eta_nonce  out  16    current nonce, zero-extended index
//   eta_done   in   1     engine completion level
//   eta_poly   in   8192  engine result, valid while eta_done is high
//   wr_en      out  1     one-cycle write strobe to the polynomial store
//   wr_idx     out  4     destination slot (= nonce)
//   wr_data    out  8192  registered copy of eta_poly
//
// Parameters
//   L, K        polynomial counts of s1 and s2; L+K must not exceed 16
//   GAP_CYCLES  idle cycles between requests (engine return-to-idle), >= 1
// ---------------------------------------------------------------------------
module polyvec_eta_scheduler #(
    parameter int L          = 4,
    parameter int K          = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [511:0]  seed,
    output logic          busy,
    output logic          done,
    output logic          eta_start,
    output logic [511:0]  eta_seed,
    output logic [15:0]   eta_nonce,
    input  logic          eta_done,
    input  logic [8191:0] eta_poly,
    output logic          wr_en,
    output logic [3:0]    wr_idx,
    output logic [8191:0] wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPTURE,
        RELEASE,
        GAP,
        FINISH
    } state_t;

    localparam int          TOTAL    = L + K;
    localparam logic [3:0]  LAST_IDX = 4'(TOTAL - 1);
    localparam int          GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [3:0]       idx;
    logic [GAP_W-1:0] gap_cnt;

    // NOTE: all state and registered outputs live in one clocked block and are
    // assigned with <= only, so every read sees the pre-edge value and the
    // ordering of statements inside the block cannot change behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            eta_start <= 1'b0;
            wr_en     <= 1'b0;
            eta_seed  <= '0;
            eta_nonce <= '0;
            wr_idx    <= '0;
            wr_data   <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
        end else begin
            // Strobes default low; the states below raise them for one cycle.
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        eta_seed  <= seed;
                        idx       <= '0;
                        eta_nonce <= '0;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end

                REQ: begin
                    eta_start <= 1'b1;
                    eta_nonce <= {12'b0, idx};
                    // Qualifying with the registered eta_start discards a done
                    // level left over from before this request was raised.
                    if (eta_start && eta_done) begin
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    wr_data   <= eta_poly;
                    wr_idx    <= idx;
                    wr_en     <= 1'b1;
                    eta_start <= 1'b0;
                    state     <= RELEASE;
                end

                RELEASE: begin
                    eta_start <= 1'b0;
                    // The engine must drop done before the gap count starts,
                    // so a slow return-to-idle simply stretches this state.
                    if (!eta_done) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (idx == LAST_IDX) begin
                            // done/busy change on entry so FINISH itself shows
                            // the pulse; the last wr_en is already long gone.
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end else begin
                            idx       <= idx + 4'd1;
                            eta_nonce <= {12'b0, idx + 4'd1};
                            state     <= REQ;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Run invariants: the store never sees a write in the done cycle, and the
    // seed presented to the engine does not move once a run is under way.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(done && wr_en));
        end
    end

    assert property (@(posedge clock) disable iff (reset)
        (busy && $past(busy)) |-> (eta_seed == $past(eta_seed)));

endmodule

// File: tb/tb_polyvec_eta_scheduler.sv
// ---------------------------------------------------------------------------
// tb_polyvec_eta_scheduler
//
// Directed bench for polyvec_eta_scheduler with a behavioural eta engine:
// done rises a fixed latency after eta_start, the result is the nonce
// replicated across all 512 16-bit lanes, and done may be held for extra
// cycles after eta_start drops. A negedge monitor scores every write, request
// and done pulse against the expected index sequence of the current run.
// ---------------------------------------------------------------------------
module tb_polyvec_eta_scheduler;

    localparam int L          = 4;
    localparam int K          = 4;
    localparam int GAP_CYCLES = 2;
    localparam int TOTAL      = L + K;

    logic          clock;
    logic          reset;
    logic          start;
    logic [511:0]  seed;
    logic          busy;
    logic          done;
    logic          eta_start;
    logic [511:0]  eta_seed;
    logic [15:0]   eta_nonce;
    logic          eta_done;
    logic [8191:0] eta_poly;
    logic          wr_en;
    logic [3:0]    wr_idx;
    logic [8191:0] wr_data;

    polyvec_eta_scheduler #(
        .L          (L),
        .K          (K),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .eta_start (eta_start),
        .eta_seed  (eta_seed),
        .eta_nonce (eta_nonce),
        .eta_done  (eta_done),
        .eta_poly  (eta_poly),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Engine model
    // ------------------------------------------------------------------
    int   latency    = 40;
    int   hold_extra = 0;
    logic stale_done = 1'b0;
    logic eng_done;
    logic eng_active;
    int   eng_cnt;
    int   hold_cnt;

    assign eta_done = eng_done | stale_done;

    always @(posedge clock) begin
        if (reset) begin
            eng_done   <= 1'b0;
            eng_active <= 1'b0;
            eng_cnt    <= 0;
            hold_cnt   <= 0;
            eta_poly   <= '0;
        end else if (eng_active) begin
            if (!eta_start) begin
                eng_active <= 1'b0;
            end else if (eng_cnt == latency - 1) begin
                eng_active <= 1'b0;
                eng_done   <= 1'b1;
                eta_poly   <= {512{eta_nonce}};
                hold_cnt   <= 0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end else if (eng_done) begin
            if (!eta_start) begin
                if (hold_cnt >= hold_extra) eng_done <= 1'b0;
                else                        hold_cnt <= hold_cnt + 1;
            end
        end else if (eta_start) begin
            eng_active <= 1'b1;
            eng_cnt    <= 0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: scores writes, requests and done pulses
    // ------------------------------------------------------------------
    int           wr_total   = 0;
    int           done_total = 0;
    int           run_base   = 0;
    logic [511:0] run_seed   = '0;
    int           quiet      = 0;
    logic         prev_start = 1'b0;
    logic [15:0]  mon_exp;

    always @(negedge clock) begin
        if (!reset) begin
            mon_exp = 16'(wr_total - run_base);
            if (wr_en) begin
                check("wr_idx", 64'(wr_idx), 64'(mon_exp));
                check("wr_data", 64'(wr_data == {512{mon_exp}}), 64'(1));
                wr_total++;
            end
            if (done) begin
                check("done_without_wr", 64'(wr_en), 64'(0));
                done_total++;
            end
            if (eta_start && !prev_start) begin
                check("eta_nonce", 64'(eta_nonce), 64'(mon_exp));
                check("eta_seed", 64'(eta_seed == run_seed), 64'(1));
                if (mon_exp != 16'd0) begin
                    check("gap_before_req", 64'(quiet >= GAP_CYCLES), 64'(1));
                end
            end
            if (eta_done)        quiet = 0;
            else if (!eta_start) quiet++;
            prev_start = eta_start;
        end
    end

    // ------------------------------------------------------------------
    // One complete run: optional start re-assertion at write 3 and an
    // optional stale done level present when the first request goes out.
    // ------------------------------------------------------------------
    task automatic run_job(input logic [511:0] s, input int hold, input bit restart, input bit stale);
        int base_d;
        int restart_left;
        bit finished;
        hold_extra = hold;
        run_seed   = s;
        run_base   = wr_total;
        base_d     = done_total;
        if (stale) stale_done = 1'b1;
        @(negedge clock);
        start = 1'b1;
        seed  = s;
        @(negedge clock);
        start = 1'b0;
        seed  = ~s;
        check("busy_after_start", 64'(busy), 64'(1));
        finished     = 1'b0;
        restart_left = 0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clock);
            if (stale && eta_start) stale_done = 1'b0;
            if (restart_left > 0) begin
                restart_left--;
                if (restart_left == 0) start = 1'b0;
            end
            if (restart && wr_en && wr_idx == 4'd3) begin
                start        = 1'b1;
                seed         = {64{8'h3C}};
                restart_left = 2;
            end
            if (done) begin
                finished = 1'b1;
                check("busy_at_done", 64'(busy), 64'(0));
            end
        end
        start = 1'b0;
        if (!finished) check("run_timeout", 64'(0), 64'(1));
        repeat (20) @(negedge clock);
        check("write_count", 64'(wr_total - run_base), 64'(TOTAL));
        check("done_count", 64'(done_total - base_d), 64'(1));
        check("busy_idle", 64'(busy), 64'(0));
        check("eta_start_idle", 64'(eta_start), 64'(0));
        check("last_wr_idx", 64'(wr_idx), 64'(TOTAL - 1));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int base_w;
        int base_d;
        bit hit;

        reset = 1'b1;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Idle after reset: everything quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_eta_start", 64'(eta_start), 64'(0));
            check("rst_wr_en", 64'(wr_en), 64'(0));
        end
        check("rst_done", 64'(done), 64'(0));
        check("rst_eta_seed", 64'(eta_seed == '0), 64'(1));
        check("rst_eta_nonce", 64'(eta_nonce), 64'(0));
        check("rst_wr_idx", 64'(wr_idx), 64'(0));
        check("rst_wr_data", 64'(wr_data == '0), 64'(1));

        // Plain run, engine drops done as soon as eta_start drops.
        run_job({64{8'hA5}}, 0, 1'b0, 1'b0);
        // Engine holds done 5 extra cycles: each request waits it out.
        run_job({64{8'h5A}}, 5, 1'b0, 1'b0);
        // start re-asserted mid-run must be ignored.
        run_job({16{32'hDEADBEEF}}, 0, 1'b1, 1'b0);
        // Stale done high when the first request is raised.
        run_job({32{16'h1234}}, 0, 1'b0, 1'b1);

        // Reset during the request for nonce 4 abandons the run.
        hold_extra = 0;
        run_seed   = {64{8'h77}};
        run_base   = wr_total;
        @(negedge clock);
        start = 1'b1;
        seed  = {64{8'h77}};
        @(negedge clock);
        start = 1'b0;
        hit   = 1'b0;
        for (int c = 0; c < 4000 && !hit; c++) begin
            @(negedge clock);
            if (eta_start && eta_nonce == 16'd4) hit = 1'b1;
        end
        check("reached_nonce4", 64'(hit), 64'(1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_eta_start", 64'(eta_start), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_wr_en", 64'(wr_en), 64'(0));
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        base_w = wr_total;
        base_d = done_total;
        repeat (100) @(negedge clock);
        check("abort_no_writes", 64'(wr_total - base_w), 64'(0));
        check("abort_no_done", 64'(done_total - base_d), 64'(0));
        check("abort_idle_start", 64'(eta_start), 64'(0));

        // Fresh run after the abort goes 0..7 again.
        run_job({64{8'hC3}}, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
